// File: rtl/core_pkg.sv
// Shared encodings and state type for the write-back stage.
package core_pkg;

  // Write-back source select (MemtoReg); the unused code 3 behaves like ALU.
  localparam logic [1:0] MTR_ALU  = 2'd0;
  localparam logic [1:0] MTR_MEM  = 2'd1;
  localparam logic [1:0] MTR_LINK = 2'd2;

  // Next-PC select (Branch).
  localparam logic [1:0] BR_SEQ  = 2'd0;
  localparam logic [1:0] BR_COND = 2'd1;
  localparam logic [1:0] BR_JUMP = 2'd2;
  localparam logic [1:0] BR_JR   = 2'd3;

  // Index of the last UART byte of a word (counter value on the final beat).
  localparam logic [1:0] UART_LAST_BYTE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } wb_state_t;

endpackage

// File: rtl/write_back_if.sv
// Bundle between memory_access / UART receiver / register file and write_back.
interface write_back_if #(
  parameter int INST_MEM_WIDTH = 14
);
  // Instruction bundle from memory_access.
  logic                      in_valid;
  logic                      RegWrite;
  logic [1:0]                MemtoReg;
  logic [1:0]                Branch;
  logic                      UARTtoReg;
  logic [31:0]               read_data;
  logic [31:0]               register_data;
  logic [31:0]               alu_result;
  logic [4:0]                rdist;
  logic [25:0]               inst_index;
  logic [INST_MEM_WIDTH-1:0] pc;
  logic [INST_MEM_WIDTH-1:0] pc1;
  logic [INST_MEM_WIDTH-1:0] pc2;
  // UART receive byte stream.
  logic [7:0]                uart_rx_data;
  logic                      uart_rx_valid;
  logic                      uart_rx_ready;
  // Pipeline control and results.
  logic                      stall;
  logic                      reg_we;
  logic [4:0]                reg_waddr;
  logic [31:0]               reg_wdata;
  logic                      pc_valid;
  logic [INST_MEM_WIDTH-1:0] next_pc;

  // Upstream side: drives the bundle and the UART stream, observes results.
  modport master (
    output in_valid, RegWrite, MemtoReg, Branch, UARTtoReg,
    output read_data, register_data, alu_result, rdist, inst_index,
    output pc, pc1, pc2, uart_rx_data, uart_rx_valid,
    input  uart_rx_ready, stall, reg_we, reg_waddr, reg_wdata,
    input  pc_valid, next_pc
  );

  // write_back side.
  modport slave (
    input  in_valid, RegWrite, MemtoReg, Branch, UARTtoReg,
    input  read_data, register_data, alu_result, rdist, inst_index,
    input  pc, pc1, pc2, uart_rx_data, uart_rx_valid,
    output uart_rx_ready, stall, reg_we, reg_waddr, reg_wdata,
    output pc_valid, next_pc
  );

endinterface

// File: rtl/write_back_uart_word_assembler.sv
// Collects four UART bytes (MSB first) into a 32-bit word under valid/ready.
module uart_word_assembler
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        start,      // clear counter/buffer for a new word
  input  logic        active,     // accepting bytes this cycle
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] word,       // last completed word, stable until next completes
  output logic        word_done   // the handshake this cycle completes the word
);

  logic [1:0]  cnt_reg;
  logic [23:0] shift_reg;
  logic [31:0] word_reg;
  logic        beat;

  assign rx_ready  = active;
  assign beat      = active && rx_valid;
  assign word_done = beat && (cnt_reg == UART_LAST_BYTE);
  assign word      = word_reg;

  // Shift bytes in; the fourth beat latches the full word so consumers
  // never see a partially assembled value.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg   <= 2'd0;
      shift_reg <= 24'd0;
      word_reg  <= 32'd0;
    end else if (start) begin
      cnt_reg   <= 2'd0;
      shift_reg <= 24'd0;
    end else if (beat) begin
      shift_reg <= {shift_reg[15:0], rx_data};
      cnt_reg   <= cnt_reg + 2'd1;
      if (cnt_reg == UART_LAST_BYTE) begin
        word_reg <= {shift_reg, rx_data};
      end
    end
  end

endmodule

// File: rtl/write_back.sv
// Final pipeline stage: selects register write-back data and the next PC,
// with an optional four-byte UART receive that stalls the pipeline.
module write_back #(
  parameter int INST_MEM_WIDTH = 14
) (
  input  logic       CLK,
  input  logic       reset,
  write_back_if.slave bus
);
  import core_pkg::*;

  wb_state_t                 state_reg;
  wb_state_t                 state_next;
  logic                      retire;
  logic                      stall;
  logic                      asm_start;
  logic                      asm_active;
  logic                      word_done;
  logic [31:0]               uart_word;
  logic [31:0]               wdata_sel;
  logic [INST_MEM_WIDTH-1:0] pc_sel;

  logic                      reg_we_reg;
  logic [4:0]                reg_waddr_reg;
  logic [31:0]               reg_wdata_reg;
  logic                      pc_valid_reg;
  logic [INST_MEM_WIDTH-1:0] next_pc_reg;

  uart_word_assembler u_asm (
    .clk       (CLK),
    .srst      (reset),
    .start     (asm_start),
    .active    (asm_active),
    .rx_data   (bus.uart_rx_data),
    .rx_valid  (bus.uart_rx_valid),
    .rx_ready  (bus.uart_rx_ready),
    .word      (uart_word),
    .word_done (word_done)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, stall and retire decode.
  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    stall      = 1'b0;
    asm_start  = 1'b0;
    asm_active = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.UARTtoReg) begin
            state_next = RECV;
            asm_start  = 1'b1;
            stall      = 1'b1;
          end else begin
            retire = 1'b1;
          end
        end
      end
      RECV: begin
        asm_active = 1'b1;
        stall      = 1'b1;
        if (word_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Upstream still holds the bundle here; stall drops so it advances on this edge.
        retire     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Write-back data select; the UART word wins over MemtoReg.
  always_comb begin
    wdata_sel = bus.alu_result;
    if (state_reg == DONE) begin
      wdata_sel = uart_word;
    end else begin
      case (bus.MemtoReg)
        MTR_MEM:  wdata_sel = bus.read_data;
        MTR_LINK: wdata_sel = 32'(bus.pc1);
        default:  wdata_sel = bus.alu_result;
      endcase
    end
  end

  // Next-PC select; targets are truncated to the instruction address width.
  always_comb begin
    pc_sel = bus.pc1;
    case (bus.Branch)
      BR_COND: pc_sel = bus.alu_result[0] ? bus.pc2 : bus.pc1;
      BR_JUMP: pc_sel = bus.inst_index[INST_MEM_WIDTH-1:0];
      BR_JR:   pc_sel = bus.register_data[INST_MEM_WIDTH-1:0];
      default: pc_sel = bus.pc1;
    endcase
  end

  // Registered retire outputs; writes to $zero are suppressed.
  always_ff @(posedge CLK) begin
    if (reset) begin
      reg_we_reg    <= 1'b0;
      reg_waddr_reg <= 5'd0;
      reg_wdata_reg <= 32'd0;
      pc_valid_reg  <= 1'b0;
      next_pc_reg   <= '0;
    end else begin
      reg_we_reg   <= retire && bus.RegWrite && (bus.rdist != 5'd0);
      pc_valid_reg <= retire;
      if (retire) begin
        reg_waddr_reg <= bus.rdist;
        reg_wdata_reg <= wdata_sel;
        next_pc_reg   <= pc_sel;
      end
    end
  end

  assign bus.stall     = stall;
  assign bus.reg_we    = reg_we_reg;
  assign bus.reg_waddr = reg_waddr_reg;
  assign bus.reg_wdata = reg_wdata_reg;
  assign bus.pc_valid  = pc_valid_reg;
  assign bus.next_pc   = next_pc_reg;

endmodule

// File: tb/tb_write_back.sv
// Randomized self-checking bench for write_back against a transaction-level model.
module tb_write_back;
  import core_pkg::*;

  localparam int IMW = 14;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  write_back_if #(.INST_MEM_WIDTH(IMW)) bus ();

  write_back #(.INST_MEM_WIDTH(IMW)) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic            regwrite;
    logic [1:0]      mtr;
    logic [1:0]      br;
    logic            uart;
    logic [31:0]     rd_data;
    logic [31:0]     reg_data;
    logic [31:0]     alu;
    logic [4:0]      rdist;
    logic [25:0]     idx;
    logic [IMW-1:0]  pc;
    logic [IMW-1:0]  pc1;
    logic [IMW-1:0]  pc2;
  } txn_t;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: value written back for a retired instruction.
  function automatic logic [31:0] model_wdata(input txn_t t, input logic [31:0] word);
    if (t.uart) return word;
    if (t.mtr == 2'd1) return t.rd_data;
    if (t.mtr == 2'd2) return {18'd0, t.pc1};
    return t.alu;
  endfunction

  // Reference model: resolved next PC, truncated by modular arithmetic.
  function automatic logic [31:0] model_pc(input txn_t t);
    logic [31:0] span;
    span = 32'd1 << IMW;
    if (t.br == 2'd1) return ((t.alu % 2) == 1) ? {18'd0, t.pc2} : {18'd0, t.pc1};
    if (t.br == 2'd2) return {6'd0, t.idx} % span;
    if (t.br == 2'd3) return t.reg_data % span;
    return {18'd0, t.pc1};
  endfunction

  function automatic txn_t blank_txn();
    txn_t t;
    t.regwrite = 1'b0; t.mtr = 2'd0; t.br = 2'd0; t.uart = 1'b0;
    t.rd_data = 32'd0; t.reg_data = 32'd0; t.alu = 32'd0; t.rdist = 5'd0;
    t.idx = 26'd0; t.pc = '0; t.pc1 = '0; t.pc2 = '0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.regwrite = 1'($urandom_range(0, 1));
    t.mtr      = 2'($urandom_range(0, 3));
    t.br       = 2'($urandom_range(0, 3));
    t.uart     = ($urandom_range(0, 3) == 0);
    t.rd_data  = $urandom;
    t.reg_data = $urandom;
    t.alu      = $urandom;
    t.rdist    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    t.idx      = 26'($urandom);
    t.pc       = IMW'($urandom);
    t.pc1      = IMW'($urandom);
    t.pc2      = IMW'($urandom);
    return t;
  endfunction

  task automatic apply(input txn_t t);
    bus.RegWrite      = t.regwrite;
    bus.MemtoReg      = t.mtr;
    bus.Branch        = t.br;
    bus.UARTtoReg     = t.uart;
    bus.read_data     = t.rd_data;
    bus.register_data = t.reg_data;
    bus.alu_result    = t.alu;
    bus.rdist         = t.rdist;
    bus.inst_index    = t.idx;
    bus.pc            = t.pc;
    bus.pc1           = t.pc1;
    bus.pc2           = t.pc2;
  endtask

  task automatic check_retire(input txn_t t, input logic [31:0] word);
    check_eq("reg_we", 32'(bus.reg_we), 32'(t.regwrite && (t.rdist != 5'd0)));
    check_eq("reg_waddr", 32'(bus.reg_waddr), 32'(t.rdist));
    check_eq("reg_wdata", bus.reg_wdata, model_wdata(t, word));
    check_eq("pc_valid", 32'(bus.pc_valid), 32'd1);
    check_eq("next_pc", 32'(bus.next_pc), model_pc(t));
    $display("txn uart=%0d mtr=%0d br=%0d rd=%0d -> we=%0d wdata=%h next_pc=%h",
             t.uart, t.mtr, t.br, t.rdist, bus.reg_we, bus.reg_wdata, bus.next_pc);
  endtask

  // One idle cycle after each instruction: nothing retires.
  task automatic idle_cycle();
    @(negedge clk);
    bus.in_valid      = 1'b0;
    bus.uart_rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle_reg_we", 32'(bus.reg_we), 32'd0);
    check_eq("idle_pc_valid", 32'(bus.pc_valid), 32'd0);
  endtask

  task automatic run_plain(input txn_t t);
    @(negedge clk);
    apply(t);
    bus.in_valid = 1'b1;
    #1;
    check_eq("plain_stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    check_retire(t, 32'd0);
    idle_cycle();
  endtask

  // UART instruction: bytes offered with random gaps in [gmin, gmax].
  task automatic run_uart(input txn_t t, input logic [31:0] word, input int gmin, input int gmax);
    logic [7:0] bytes [4];
    int got;
    int gap;
    logic offered;
    bytes[0] = word[31:24]; bytes[1] = word[23:16];
    bytes[2] = word[15:8];  bytes[3] = word[7:0];
    got = 0;
    @(negedge clk);
    apply(t);
    bus.in_valid      = 1'b1;
    bus.uart_rx_valid = 1'($urandom_range(0, 1));
    bus.uart_rx_data  = 8'hee;   // a byte offered before RECV must be ignored
    #1;
    check_eq("uart_start_stall", 32'(bus.stall), 32'd1);
    check_eq("uart_start_ready", 32'(bus.uart_rx_ready), 32'd0);
    @(posedge clk);
    #1;
    check_eq("uart_start_we", 32'(bus.reg_we), 32'd0);
    gap = $urandom_range(gmin, gmax);
    for (int cyc = 0; cyc < 200 && got < 4; cyc++) begin
      @(negedge clk);
      offered = (gap == 0);
      bus.uart_rx_valid = offered;
      bus.uart_rx_data  = offered ? bytes[got] : 8'($urandom);
      if (!offered) gap--;
      #1;
      check_eq("recv_stall", 32'(bus.stall), 32'd1);
      check_eq("recv_ready", 32'(bus.uart_rx_ready), 32'd1);
      @(posedge clk);
      if (offered) begin
        got++;
        gap = $urandom_range(gmin, gmax);
      end
      #1;
      check_eq("recv_no_we", 32'(bus.reg_we), 32'd0);
    end
    check_eq("uart_bytes_timeout", got, 4);
    @(negedge clk);
    bus.uart_rx_valid = 1'b1;    // still offered, must not be taken in DONE
    bus.uart_rx_data  = 8'hab;
    #1;
    check_eq("done_stall", 32'(bus.stall), 32'd0);
    check_eq("done_ready", 32'(bus.uart_rx_ready), 32'd0);
    @(posedge clk);
    #1;
    check_retire(t, word);
    idle_cycle();
  endtask

  initial begin
    txn_t t;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.uart_rx_valid = 1'b0;
    bus.uart_rx_data = 8'd0;
    apply(blank_txn());
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_reg_we", 32'(bus.reg_we), 32'd0);
    check_eq("rst_reg_waddr", 32'(bus.reg_waddr), 32'd0);
    check_eq("rst_reg_wdata", bus.reg_wdata, 32'd0);
    check_eq("rst_pc_valid", 32'(bus.pc_valid), 32'd0);
    check_eq("rst_next_pc", 32'(bus.next_pc), 32'd0);
    check_eq("rst_stall", 32'(bus.stall), 32'd0);
    check_eq("rst_ready", 32'(bus.uart_rx_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ALU write.
    t = blank_txn();
    t.regwrite = 1'b1; t.alu = 32'hffffffff; t.rdist = 5'd10; t.pc1 = 14'd1;
    run_plain(t);
    check_eq("alu_next_pc_is_1", 32'(bus.next_pc), 32'd1);
    // Load, then the same into $zero.
    t = blank_txn();
    t.regwrite = 1'b1; t.mtr = 2'd1; t.rd_data = 32'h55555555; t.rdist = 5'd31;
    run_plain(t);
    t.rdist = 5'd0;
    run_plain(t);
    // Branch modes.
    t = blank_txn();
    t.br = 2'd1; t.alu = 32'd1; t.pc1 = 14'd7; t.pc2 = 14'd3;
    run_plain(t);
    t.alu = 32'h2;
    run_plain(t);
    t.br = 2'd2; t.idx = 26'h0000002;
    run_plain(t);
    t.br = 2'd3; t.reg_data = 32'h10101011;
    run_plain(t);
    check_eq("jr_truncated", 32'(bus.next_pc), 32'h1011);
    // Link.
    t = blank_txn();
    t.regwrite = 1'b1; t.mtr = 2'd2; t.pc1 = 14'h2abc; t.rdist = 5'd31;
    run_plain(t);

    // UART word with 2-cycle gaps.
    t = blank_txn();
    t.uart = 1'b1; t.regwrite = 1'b1; t.rdist = 5'd3; t.pc1 = 14'd9;
    run_uart(t, 32'h12345678, 2, 2);
    // UART word with no gaps (minimum latency path).
    run_uart(t, 32'hcafef00d, 0, 0);

    // Reset in the middle of a UART receive.
    @(negedge clk);
    apply(t);
    bus.in_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.uart_rx_valid = 1'b1;
      bus.uart_rx_data  = 8'h11 * 8'(k + 1);
      @(posedge clk);
    end
    @(negedge clk);
    bus.uart_rx_valid = 1'b0;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_reg_we", 32'(bus.reg_we), 32'd0);
    check_eq("midrst_wdata", bus.reg_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("midrst_stall", 32'(bus.stall), 32'd0);
    check_eq("midrst_ready", 32'(bus.uart_rx_ready), 32'd0);
    @(posedge clk);
    #1;
    check_eq("midrst_after_we", 32'(bus.reg_we), 32'd0);
    run_uart(t, 32'h9abcdef0, 0, 1);

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      t = rand_txn();
      if (t.uart) run_uart(t, $urandom, 0, 3);
      else        run_plain(t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
